interleaver: RTL and testbench
==============================

INTERLEAVER -- requirements
Module: interleaver

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk, input, 1, rising-edge system clock.
REQ-003 Port: reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-004 Port: vld_crc, input, 1, block-start strobe from CRC stage; sampled with cbs.
REQ-005 Port: rdy_out, input, 1, downstream ready; output byte consumed when vld_out and rdy_out are both 1 at a clk edge.
REQ-006 Port: cbs, input, 1, code block size select: 0 = K 1056 bits; 1 = K 6144 bits.
REQ-007 Port: data_in, input, 8, input byte; data_in[j] carries block bit 8n+j of byte n.
REQ-008 Port: rdy_crc, output, 1, high when the block can accept a new vld_crc.
REQ-009 Port: vld_out, output, 1, data_out holds a valid interleaved byte.
REQ-010 Port: data_out, output, 8, output byte; data_out[j] carries interleaved bit 8n+j of byte n.

Function
REQ-011 Interleave law: LTE QPP, c'(i) = c(pi(i)), pi(i) = (f1*i + f2*i*i) mod K, for i = 0..K-1.
REQ-012 Parameters: K=1056 -> f1=17, f2=66; K=6144 -> f1=263, f2=480.
REQ-013 Index generation SHALL be recursive, with no multipliers:
- pi(0)=0, g(0)=(f1+f2) mod K.
- pi(i+1)=(pi(i)+g(i)) mod K.
- g(i+1)=(g(i)+2*f2) mod K.
- All adds are modular, implemented as compare-and-subtract on 13-bit values.
REQ-014 Storage: 6144-bit input buffer written bytewise at byte address n; 8 independent bit-read ports addressed by pi.
REQ-015 FSM states: IDLE, LOAD, OUT.
REQ-016 IDLE behaviour:
- rdy_crc=1, vld_out=0.
- vld_crc=1 at an edge latches cbs into K, clears the byte counter, moves to LOAD.
REQ-017 LOAD behaviour:
- rdy_crc=0.
- Starting the edge after vld_crc acceptance, one data_in byte is written per edge to byte address 0,1,..., K/8-1.
- K/8 = 132 bytes (K=1056) or 768 bytes (K=6144).
- After the last byte, go to OUT.
REQ-018 OUT behaviour:
- vld_out=1.
- data_out[j] = buffer[pi(8m+j)] for current output byte m.
- Advance m and the 8-wide pi/g pipeline only on edges with rdy_out=1.
- data_out holds stable while rdy_out=0.
REQ-019 Latency: first output byte valid on the first cycle of OUT, i.e. one cycle after the last input byte is written.
REQ-020 End of block: after byte K/8-1 is consumed, deassert vld_out, return to IDLE, and assert rdy_crc the same cycle.
REQ-021 vld_crc and cbs are ignored outside IDLE; cbs changes mid-block have no effect.
REQ-022 Buffer contents are not cleared between blocks; every bit read in OUT was written in the preceding LOAD.
REQ-023 Asserting reset mid-LOAD or mid-OUT aborts the block immediately; no partial output is resumed.

Reset
REQ-024 While reset=0:
- State = IDLE.
- rdy_crc=0, vld_out=0, data_out=8'h00.
- Counters, pi and g cleared.
- K = 1056.
REQ-025 The first clk edge after reset release SHALL drive rdy_crc=1; buffer contents need no reset.

Verification
REQ-026 Reset: hold reset=0 for 3 cycles -> rdy_crc=0, vld_out=0, data_out=00; after release, rdy_crc=1.
REQ-027 Identity bit: cbs=0, vld_crc pulse, 132 bytes all 00 except byte 0 = 01 -> output byte 0 = 01 (pi(0)=0), all others 00, exactly 132 valid bytes.
REQ-028 Index 1, K=1056: only input bit 83 set (byte 10 = 08) -> output byte 0 = 02; only bit 298 set (byte 37 = 04) -> output byte 0 = 04.
REQ-029 Index 1, K=6144: cbs=1, 768 bytes, only bit 743 set (byte 92 = 80) -> output byte 0 = 02, 768 output bytes, then rdy_crc=1.
REQ-030 Backpressure: toggle rdy_out randomly during OUT -> output sequence identical to the rdy_out=1 run; data_out stable while stalled.
REQ-031 Full vector: random 1056-bit block -> output matches a software QPP model (f1=17, f2=66) bit-for-bit; reset asserted mid-OUT -> vld_out=0 immediately.

Source files
------------

// File: rtl/interleaver.sv
// LTE QPP bit interleaver for code blocks of K=1056 or K=6144 bits.
// Input bytes are buffered, then read back eight bits per cycle at the
// recursively generated QPP indices pi(8m)..pi(8m+7). No multipliers are used.
module interleaver (
    input  logic       clk,
    input  logic       reset,
    input  logic       vld_crc,
    input  logic       rdy_out,
    input  logic       cbs,
    input  logic [7:0] data_in,
    output logic       rdy_crc,
    output logic       vld_out,
    output logic [7:0] data_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_OUT  = 2'd2
    } state_e;

    // Per-size constants: K, g(0) = f1+f2, increment 2*f2, last byte index.
    localparam logic [12:0] K_SMALL    = 13'd1056;
    localparam logic [12:0] K_LARGE    = 13'd6144;
    localparam logic [12:0] G0_SMALL   = 13'd83;
    localparam logic [12:0] G0_LARGE   = 13'd743;
    localparam logic [12:0] DG_SMALL   = 13'd132;
    localparam logic [12:0] DG_LARGE   = 13'd960;
    localparam logic [9:0]  LAST_SMALL = 10'd131;
    localparam logic [9:0]  LAST_LARGE = 10'd767;

    // Modular add of two values already below k: compare-and-subtract.
    function automatic logic [12:0] add_mod(input logic [12:0] a,
                                            input logic [12:0] b,
                                            input logic [12:0] k);
        logic [13:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, k}) begin
            s = s - {1'b0, k};
        end else begin
            s = s;
        end
        return s[12:0];
    endfunction

    state_e            state_q, state_d;
    logic              cbs_q, cbs_d;
    logic [9:0]        cnt_q, cnt_d;
    logic [7:0][12:0]  pi_q, pi_d;
    logic [7:0][12:0]  g_q, g_d;
    logic              rdy_q, rdy_d;
    logic              vld_q, vld_d;
    logic [7:0]        dout_q, dout_d;
    logic [6143:0]     buf_q;

    logic              cbs_sel_s;
    logic [12:0]       k_s, g0_s, dg_s;
    logic [9:0]        last_s;
    logic [12:0]       seed_pi_s, seed_g_s;
    logic [7:0][12:0]  lane_pi_s, lane_g_s, rd_pi_s;
    logic [7:0]        rd_bits_s;
    logic              wr_en_s;

    // Block-size constants: live cbs while idle (for acceptance), latched size otherwise.
    always_comb begin
        cbs_sel_s = (state_q == S_IDLE) ? cbs : cbs_q;
        if (cbs_sel_s) begin
            k_s  = K_LARGE;
            g0_s = G0_LARGE;
            dg_s = DG_LARGE;
        end else begin
            k_s  = K_SMALL;
            g0_s = G0_SMALL;
            dg_s = DG_SMALL;
        end
        last_s = cbs_q ? LAST_LARGE : LAST_SMALL;
    end

    // Eight-lane pi/g recursion: seeded at block start or from the last lane of the current byte.
    always_comb begin
        lane_pi_s = '0;
        lane_g_s  = '0;
        if (state_q == S_IDLE) begin
            seed_pi_s = 13'd0;
            seed_g_s  = g0_s;
        end else begin
            seed_pi_s = add_mod(pi_q[7], g_q[7], k_s);
            seed_g_s  = add_mod(g_q[7], dg_s, k_s);
        end
        lane_pi_s[0] = seed_pi_s;
        lane_g_s[0]  = seed_g_s;
        for (int j = 1; j < 8; j++) begin
            lane_pi_s[j] = add_mod(lane_pi_s[j-1], lane_g_s[j-1], k_s);
            lane_g_s[j]  = add_mod(lane_g_s[j-1], dg_s, k_s);
        end
    end

    // Eight bit-read ports; while loading, the byte being written is forwarded so
    // the first output byte is ready on the first OUT cycle.
    always_comb begin
        wr_en_s   = (state_q == S_LOAD);
        rd_pi_s   = '0;
        rd_bits_s = 8'h00;
        for (int j = 0; j < 8; j++) begin
            rd_pi_s[j] = wr_en_s ? pi_q[j] : lane_pi_s[j];
            if (wr_en_s && (rd_pi_s[j][12:3] == cnt_q)) begin
                rd_bits_s[j] = data_in[rd_pi_s[j][2:0]];
            end else begin
                rd_bits_s[j] = buf_q[rd_pi_s[j]];
            end
        end
    end

    // FSM next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cbs_d   = cbs_q;
        cnt_d   = cnt_q;
        pi_d    = pi_q;
        g_d     = g_q;
        rdy_d   = rdy_q;
        vld_d   = vld_q;
        dout_d  = dout_q;
        case (state_q)
            S_IDLE: begin
                rdy_d  = 1'b1;
                vld_d  = 1'b0;
                dout_d = 8'h00;
                if (vld_crc && rdy_q) begin
                    state_d = S_LOAD;
                    cbs_d   = cbs;
                    cnt_d   = 10'd0;
                    pi_d    = lane_pi_s;
                    g_d     = lane_g_s;
                    rdy_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                rdy_d = 1'b0;
                vld_d = 1'b0;
                cnt_d = cnt_q + 10'd1;
                if (cnt_q == last_s) begin
                    state_d = S_OUT;
                    cnt_d   = 10'd0;
                    vld_d   = 1'b1;
                    dout_d  = rd_bits_s;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_OUT: begin
                rdy_d = 1'b0;
                vld_d = 1'b1;
                if (rdy_out) begin
                    if (cnt_q == last_s) begin
                        state_d = S_IDLE;
                        cnt_d   = 10'd0;
                        vld_d   = 1'b0;
                        rdy_d   = 1'b1;
                        dout_d  = 8'h00;
                    end else begin
                        cnt_d  = cnt_q + 10'd1;
                        pi_d   = lane_pi_s;
                        g_d    = lane_g_s;
                        dout_d = rd_bits_s;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 10'd0;
                rdy_d   = 1'b0;
                vld_d   = 1'b0;
                dout_d  = 8'h00;
            end
        endcase
    end

    // State and control registers with asynchronous abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cbs_q   <= 1'b0;
            cnt_q   <= 10'd0;
            pi_q    <= '0;
            g_q     <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            dout_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cbs_q   <= cbs_d;
            cnt_q   <= cnt_d;
            pi_q    <= pi_d;
            g_q     <= g_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            dout_q  <= dout_d;
        end
    end

    // Block buffer: one byte per LOAD cycle; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            buf_q[{cnt_q, 3'b000} +: 8] <= data_in;
        end
    end

    assign rdy_crc  = rdy_q;
    assign vld_out  = vld_q;
    assign data_out = dout_q;

endmodule

// File: tb/tb_interleaver.sv
// Self-checking bench for the QPP interleaver: a direct-formula QPP model
// builds the expected byte stream; a negedge monitor compares every valid cycle.
module tb_interleaver;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       vld_crc = 1'b0;
    logic       rdy_out = 1'b1;
    logic       cbs = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       rdy_crc;
    logic       vld_out;
    logic [7:0] data_out;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         out_idx = 0;
    logic [7:0] first_out = 8'h00;
    logic [7:0] exp_q[$];
    logic [7:0] blk[0:767];

    interleaver dut (
        .clk      (clk),
        .reset    (reset),
        .vld_crc  (vld_crc),
        .rdy_out  (rdy_out),
        .cbs      (cbs),
        .data_in  (data_in),
        .rdy_crc  (rdy_crc),
        .vld_out  (vld_out),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Direct QPP formula with multiplications.
    function automatic int qpp(input int i, input int k);
        longint f1, f2, ii;
        f1 = (k == 1056) ? 17 : 263;
        f2 = (k == 1056) ? 66 : 480;
        ii = i;
        return int'((f1 * ii + f2 * ii * ii) % longint'(k));
    endfunction

    // Monitor: every valid cycle must show the model byte for the current index.
    always @(negedge clk) begin
        if (reset && vld_out) begin
            if (out_idx < exp_q.size()) begin
                check("data_out", data_out, exp_q[out_idx]);
                if (out_idx == 0) first_out = data_out;
            end else begin
                n_tests++;
                n_fail++;
                $display("FAIL extra_vld: vld_out high after %0d bytes", out_idx);
            end
            if (rdy_out) out_idx++;
        end
    end

    task automatic fill(input int nb, input int rnd);
        for (int n = 0; n < 768; n++) blk[n] = 8'h00;
        if (rnd != 0) begin
            for (int n = 0; n < nb; n++) blk[n] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic run_block(input logic c, input int rnd_rdy, input int abort_at);
        int nb, k, p, cyc, aborted;
        logic [7:0] b;
        nb = c ? 768 : 132;
        k  = c ? 6144 : 1056;
        exp_q.delete();
        for (int m = 0; m < nb; m++) begin
            for (int j = 0; j < 8; j++) begin
                p = qpp(8 * m + j, k);
                b[j] = blk[p / 8][p % 8];
            end
            exp_q.push_back(b);
        end
        out_idx = 0;
        aborted = 0;
        cyc = 0;
        while (!rdy_crc && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        check("start_rdy_crc", rdy_crc, 1);
        vld_crc = 1'b1;
        cbs = c;
        @(posedge clk); #1;
        check("load_rdy_crc", rdy_crc, 0);
        for (int n = 0; n < nb; n++) begin
            vld_crc = 1'($urandom_range(0, 1));
            cbs     = 1'($urandom_range(0, 1));
            data_in = blk[n];
            @(posedge clk); #1;
        end
        vld_crc = 1'b0;
        check("latency_vld", vld_out, 1);
        check("latency_byte0", data_out, exp_q[0]);
        rdy_out = (rnd_rdy != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        cyc = 0;
        while (vld_out && cyc < 20000 && aborted == 0) begin
            if (abort_at >= 0 && out_idx >= abort_at) begin
                reset = 1'b0;
                #1;
                check("abort_vld", vld_out, 0);
                check("abort_rdy", rdy_crc, 0);
                check("abort_dout", data_out, 0);
                aborted = 1;
            end else begin
                @(posedge clk); #1;
                cyc++;
                rdy_out = (rnd_rdy != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        rdy_out = 1'b1;
        if (aborted == 0) begin
            check("out_count", out_idx, nb);
            check("end_vld", vld_out, 0);
            check("end_rdy_crc", rdy_crc, 1);
        end else begin
            repeat (2) @(posedge clk);
            #1 reset = 1'b1;
            @(posedge clk); #1;
            check("abort_recover_rdy", rdy_crc, 1);
            check("abort_recover_vld", vld_out, 0);
        end
    endtask

    initial begin
        // Reset held for three cycles.
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy_crc", rdy_crc, 0);
        check("rst_vld_out", vld_out, 0);
        check("rst_data_out", data_out, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_release_rdy", rdy_crc, 1);

        // Model pins against hand-computed QPP indices.
        check("model_pi1_1056", qpp(1, 1056), 83);
        check("model_pi2_1056", qpp(2, 1056), 298);
        check("model_pi1_6144", qpp(1, 6144), 743);

        // Identity bit.
        fill(132, 0);
        blk[0] = 8'h01;
        run_block(1'b0, 0, -1);
        check("ident_first", first_out, 8'h01);

        // Index 1 and 2, K=1056.
        fill(132, 0);
        blk[10] = 8'h08;
        run_block(1'b0, 0, -1);
        check("k1056_bit83", first_out, 8'h02);
        fill(132, 0);
        blk[37] = 8'h04;
        run_block(1'b0, 0, -1);
        check("k1056_bit298", first_out, 8'h04);

        // Index 1, K=6144.
        fill(768, 0);
        blk[92] = 8'h80;
        run_block(1'b1, 0, -1);
        check("k6144_bit743", first_out, 8'h02);

        // Random blocks, with and without backpressure.
        fill(132, 1);
        run_block(1'b0, 0, -1);
        run_block(1'b0, 1, -1);
        fill(768, 1);
        run_block(1'b1, 1, -1);

        // Reset mid-OUT, then a clean block afterwards.
        fill(132, 1);
        run_block(1'b0, 1, 40);
        fill(132, 1);
        run_block(1'b0, 1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
